// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: NOP encoding, fetch FSM states, reset vector.
package cpu_pkg;

    // addi x0, x0, 0 -- the canonical bubble instruction
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } fetch_state_t;

    // Force a fetch target onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect
// squash state machine and a counter of real instructions handed to decode.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int unsigned SQUASH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] imem_insn,
    output logic [31:0] imem_addr,
    output logic        branch_jump_stall,
    output logic [31:0] fetch_count
);

    // Counter load value on redirect; only meaningful when bubbles are configured
    localparam logic [1:0] SQUASH_INIT = (SQUASH_CYCLES > 0) ? 2'(SQUASH_CYCLES - 1) : 2'd0;

    logic [31:0]  pc_r;
    logic [31:0]  insn_r;
    logic [31:0]  addr_r;
    logic [31:0]  count_r;
    fetch_state_t state_r;
    logic [1:0]   squash_cnt_r;

    // PC, IF/ID register, squash FSM and fetch counter; redirect beats stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            insn_r       <= NOP_INSN;
            addr_r       <= 32'd0;
            count_r      <= 32'd0;
            state_r      <= RUN;
            squash_cnt_r <= 2'd0;
        end else if (redirect) begin
            pc_r   <= word_align(redirect_addr);
            insn_r <= NOP_INSN;
            addr_r <= 32'd0;
            if (SQUASH_CYCLES > 0) begin
                state_r      <= SQUASH;
                squash_cnt_r <= SQUASH_INIT;
            end else begin
                state_r      <= RUN;
                squash_cnt_r <= 2'd0;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (!stall) begin
                        pc_r    <= pc_r + 32'd4;
                        insn_r  <= imem_rdata;
                        addr_r  <= pc_r;
                        count_r <= count_r + 32'd1;
                    end else begin
                        pc_r    <= pc_r;
                        insn_r  <= insn_r;
                        addr_r  <= addr_r;
                        count_r <= count_r;
                    end
                end
                SQUASH: begin
                    // Bubbles are injected regardless of stall; PC waits at the target
                    insn_r <= NOP_INSN;
                    addr_r <= 32'd0;
                    if (squash_cnt_r == 2'd0) begin
                        state_r <= RUN;
                    end else begin
                        squash_cnt_r <= squash_cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r      <= RUN;
                    squash_cnt_r <= 2'd0;
                    insn_r       <= NOP_INSN;
                    addr_r       <= 32'd0;
                end
            endcase
        end
    end

    // Flush request: live redirect or pending bubbles; masked during reset so
    // it tracks redirect alone while rst_n is low
    assign branch_jump_stall = redirect | (rst_n & (state_r == SQUASH));

    assign pc          = pc_r;
    assign imem_insn   = insn_r;
    assign imem_addr   = addr_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: two instances (0 and 2 squash
// bubbles) share stimulus; a bubble-counting reference model predicts both.
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, redirect;
    logic [31:0] redirect_addr;
    logic [31:0] pc0, insn0, addr0, cnt0, rdata0;
    logic [31:0] pc2, insn2, addr2, cnt2, rdata2;
    logic        bjs0, bjs2;

    int errors = 0;
    int checks = 0;

    // Instruction memory image: word i holds 0x100 + i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0100 + {2'b00, a[31:2]};
    endfunction

    assign rdata0 = mem_word(pc0);
    assign rdata2 = mem_word(pc2);

    instruction_fetch #(.RESET_PC(32'h0000_0000), .SQUASH_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_rdata(rdata0), .pc(pc0),
        .imem_insn(insn0), .imem_addr(addr0), .branch_jump_stall(bjs0),
        .fetch_count(cnt0));

    instruction_fetch #(.RESET_PC(32'h0000_0000), .SQUASH_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_rdata(rdata2), .pc(pc2),
        .imem_insn(insn2), .imem_addr(addr2), .branch_jump_stall(bjs2),
        .fetch_count(cnt2));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, PC / IF-ID / count plus bubbles still owed
    logic [31:0] m_pc[2], m_insn[2], m_addr[2], m_cnt[2];
    int          m_bub[2];

    function automatic int sq_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic exp_bjs(input int k);
        return redirect || (rst_n && (m_bub[k] > 0));
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k] = 32'd0; m_insn[k] = NOP_INSN; m_addr[k] = 32'd0;
                m_cnt[k] = 32'd0; m_bub[k] = 0;
            end else if (redirect) begin
                m_pc[k] = redirect_addr & 32'hFFFF_FFFC;
                m_insn[k] = NOP_INSN; m_addr[k] = 32'd0; m_bub[k] = sq_of(k);
            end else if (m_bub[k] > 0) begin
                m_insn[k] = NOP_INSN; m_addr[k] = 32'd0; m_bub[k] = m_bub[k] - 1;
            end else if (!stall) begin
                m_insn[k] = mem_word(m_pc[k]); m_addr[k] = m_pc[k];
                m_pc[k] = m_pc[k] + 32'd4; m_cnt[k] = m_cnt[k] + 32'd1;
            end
        end
    endtask

    // One clock: check flush outputs, advance the model, check registered outputs
    task automatic tick();
        #1;
        check_val("bjs0", {31'd0, bjs0}, {31'd0, exp_bjs(0)});
        check_val("bjs2", {31'd0, bjs2}, {31'd0, exp_bjs(1)});
        @(posedge clk);
        model_step();
        #1;
        check_val("pc0", pc0, m_pc[0]);     check_val("pc2", pc2, m_pc[1]);
        check_val("insn0", insn0, m_insn[0]); check_val("insn2", insn2, m_insn[1]);
        check_val("addr0", addr0, m_addr[0]); check_val("addr2", addr2, m_addr[1]);
        check_val("cnt0", cnt0, m_cnt[0]);   check_val("cnt2", cnt2, m_cnt[1]);
        @(negedge clk);
    endtask

    initial begin
        int          hi;
        logic [31:0] c_before;
        logic        saw_80;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
        for (int k = 0; k < 2; k++) m_bub[k] = 0;
        @(negedge clk);

        // Reset state
        tick(); tick();
        check_val("rst_pc", pc0, 32'd0);
        check_val("rst_insn", insn0, NOP_INSN);
        check_val("rst_cnt", cnt0, 32'd0);

        // Free run of four edges
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("run_pc", pc0, 32'd16);
        check_val("run_insn", insn0, 32'h0000_0103);
        check_val("run_addr", addr0, 32'd12);
        check_val("run_cnt", cnt0, 32'd4);

        // Stall three cycles with pc=8
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("stall_pc", pc0, 32'd8);
        check_val("stall_insn", insn0, 32'h0000_0101);
        check_val("stall_addr", addr0, 32'd4);
        check_val("stall_cnt", cnt0, 32'd2);
        stall = 1'b0; tick();
        check_val("resume_insn", insn0, 32'h0000_0102);
        check_val("resume_addr", addr0, 32'd8);

        // Redirect beats stall, unaligned target
        redirect = 1'b1; redirect_addr = 32'h0000_0043; stall = 1'b1;
        #1 check_val("rd_bjs", {31'd0, bjs0}, 32'd1);
        tick();
        check_val("rd_pc", pc0, 32'h0000_0040);
        check_val("rd_insn", insn0, NOP_INSN);
        check_val("rd_cnt", cnt0, 32'd3);
        redirect = 1'b0; stall = 1'b0; tick();
        check_val("rd_addr", addr0, 32'h0000_0040);
        check_val("rd_tgt", insn0, 32'h0000_0110);
        for (int i = 0; i < 4; i++) tick();

        // Two-bubble squash to 0x80
        hi = 0; c_before = m_cnt[1];
        redirect = 1'b1; redirect_addr = 32'h0000_0080;
        for (int e = 0; e < 6; e++) begin
            #1 if (bjs2) hi++;
            tick();
            redirect = 1'b0;
            if (e == 2) begin
                check_val("sq_nop", insn2, NOP_INSN);
                check_val("sq_cnt", cnt2, c_before);
            end
            if (e == 3) check_val("sq_tgt", insn2, 32'h0000_0120);
        end
        check_val("sq_bjs_cycles", hi, 32'd3);

        // Redirect again during squash: 0x80 never delivered
        saw_80 = 1'b0;
        redirect = 1'b1; redirect_addr = 32'h0000_0080; tick();
        if (insn2 == 32'h0000_0120) saw_80 = 1'b1;
        redirect_addr = 32'h0000_00C0; tick();
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (insn2 == 32'h0000_0120) saw_80 = 1'b1;
            tick();
        end
        check_val("restart_no80", {31'd0, saw_80}, 32'd0);

        // PC wrap
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; tick();
        redirect = 1'b0; tick();
        check_val("wrap_pc", pc0, 32'd0);
        check_val("wrap_insn", insn0, 32'h4000_00FF);
        check_val("wrap_addr", addr0, 32'hFFFF_FFFC);

        // Reset in the middle of squash
        for (int i = 0; i < 4; i++) tick();
        redirect = 1'b1; redirect_addr = 32'h0000_0200; tick();
        redirect = 1'b0; rst_n = 1'b0;
        #1 check_val("rst_sq_bjs", {31'd0, bjs2}, 32'd0);
        tick();
        check_val("rst_sq_pc", pc2, 32'd0);
        check_val("rst_sq_cnt", cnt2, 32'd0);
        rst_n = 1'b1; tick();
        check_val("rst_sq_insn", insn2, 32'h0000_0100);
        check_val("rst_sq_pc1", pc2, 32'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom % 64) != 0;
            stall = ($urandom % 4) == 0;
            redirect = ($urandom % 8) == 0;
            redirect_addr = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
